ifp_fetch_unit: RTL and testbench

- Instruction-fetch (IFP) stage. Consumes the stall and redirect controls produced by the hazard unit: stall_IFP, branch_taken_IFP and branch_target_IFP.
- Owns the PC and drives a single-outstanding valid/ready request channel to instruction memory.
- Presents fetched instructions to the IFR pipeline register with a valid flag.
- Discards responses that belong to the wrong path after a redirect.

---
 rtl/ifp_fetch_unit_if.sv | 25 ++
 rtl/ifp_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_ifp_fetch_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifp_fetch_unit_if.sv
// Instruction-memory channel between the fetch unit (master) and instruction memory (slave).
// A request transfers on any cycle with imem_req_valid && imem_req_ready; the address is sampled only then.
interface ifp_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/ifp_fetch_unit.sv
// IFP fetch stage: owns the PC, keeps one request in flight to instruction memory, and feeds
// the IFR register through a one-entry skid buffer; responses from a squashed path are dropped.
module ifp_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_IFP,
    input  logic             branch_taken_IFP,
    input  logic [63:0]      branch_target_IFP,
    ifp_fetch_unit_if.master imem,
    output logic             inst_valid_IFP,
    output logic [31:0]      inst_IFP,
    output logic [63:0]      pc_IFP,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] fpc_q, fpc_d;
    logic        kill_q, kill_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] pc_out_q, pc_out_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [63:0] skid_pc_q, skid_pc_d;

    logic req_hs;
    logic slot_free;

    assign req_hs    = (state_q == S_REQ) && imem.imem_req_ready;
    assign slot_free = !inst_valid_q || !stall_IFP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            fpc_q        <= '0;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            pc_out_q     <= '0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fpc_q        <= fpc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            pc_out_q     <= pc_out_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fpc_d        = fpc_q;
        kill_d       = kill_q;
        // An unstalled output is consumed this cycle, so it survives only while stalled.
        inst_valid_d = inst_valid_q && stall_IFP;
        inst_d       = inst_q;
        pc_out_d     = pc_out_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (req_hs) begin
                    fpc_d   = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_resp_valid) begin
                    if (kill_q) begin
                        // pc already holds the redirect target; only the stale data is discarded.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        pc_d = fpc_q + PC_STEP;
                        if (slot_free) begin
                            inst_valid_d = 1'b1;
                            inst_d       = imem.imem_resp_data;
                            pc_out_d     = fpc_q;
                            state_d      = S_REQ;
                        end else begin
                            skid_inst_d = imem.imem_resp_data;
                            skid_pc_d   = fpc_q;
                            state_d     = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!stall_IFP) begin
                    inst_valid_d = 1'b1;
                    inst_d       = skid_inst_q;
                    pc_out_d     = skid_pc_q;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase

        // Redirect overrides everything above, including a stalled output.
        if (branch_taken_IFP) begin
            inst_valid_d = 1'b0;
            pc_d         = branch_target_IFP;
            skid_inst_d  = '0;
            skid_pc_d    = '0;
            case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem.imem_req_valid = (state_q == S_REQ);
        imem.imem_req_addr  = pc_q;
        inst_valid_IFP      = inst_valid_q;
        inst_IFP            = inst_q;
        pc_IFP              = pc_out_q;
        state_dbg_o         = state_q;
    end

endmodule

// File: tb/tb_ifp_fetch_unit.sv
// Directed and random checks of ifp_fetch_unit against a latency-configurable instruction memory model.
module tb_ifp_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [1:0]  ST_BOOT  = 2'd0;
    localparam logic [1:0]  ST_REQ   = 2'd1;
    localparam logic [1:0]  ST_WAIT  = 2'd2;
    localparam logic [1:0]  ST_HOLD  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic [63:0] target;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc_out;
    logic [1:0]  state_dbg;

    ifp_fetch_unit_if bus ();

    ifp_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(64'd4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_IFP        (stall),
        .branch_taken_IFP (branch),
        .branch_target_IFP(target),
        .imem             (bus),
        .inst_valid_IFP   (inst_valid),
        .inst_IFP         (inst),
        .pc_IFP           (pc_out),
        .state_dbg_o      (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_req_q[$];
    logic [63:0] exp_out_q[$];

    int          mem_lat = 1;
    bit          mem_en  = 1'b1;
    bit          inj_resp = 1'b0;
    int          acc_cnt = 0;
    logic [63:0] mon_req;
    logic [63:0] mon_pc;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_3C3C;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_accept(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) found = 1'b1;
        end
        check({tag, "_accept"}, 64'(found), 64'd1);
    endtask

    task automatic wait_out(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        check({tag, "_out"}, 64'(found), 64'd1);
    endtask

    // instruction memory model: one response per accepted request after mem_lat cycles
    initial begin
        bit          s_acc;
        bit          s_inj;
        logic [63:0] s_addr;
        int          s_lat;
        logic [63:0] pa;
        int          cd;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        pa = '0;
        cd = 0;
        forever begin
            @(negedge clk);
            s_acc  = mem_en && rst_n && bus.imem_req_valid && bus.imem_req_ready;
            s_addr = bus.imem_req_addr;
            s_lat  = mem_lat;
            s_inj  = inj_resp;
            @(posedge clk);
            #1;
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
            if (s_acc) begin
                pa = s_addr;
                cd = s_lat;
            end
            if (!rst_n) cd = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_fn(pa);
                end
            end
            if (s_inj) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // scoreboard: accepted request addresses
    always @(negedge clk) begin
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            acc_cnt++;
            if (exp_req_q.size() == 0) begin
                check("req_extra", 64'(exp_req_q.size()), 64'd1);
            end else begin
                mon_req = exp_req_q.pop_front();
                check("req_addr", bus.imem_req_addr, mon_req);
            end
        end
    end

    // scoreboard: instructions consumed by IFR
    always @(negedge clk) begin
        if (rst_n && inst_valid && !stall) begin
            if (exp_out_q.size() == 0) begin
                check("out_extra", 64'(exp_out_q.size()), 64'd1);
            end else begin
                mon_pc = exp_out_q.pop_front();
                check("out_pc", pc_out, mon_pc);
                check("out_inst", 64'(inst), 64'(mem_fn(mon_pc)));
            end
        end
    end

    // driver
    initial begin
        bit found;
        int start;
        int cyc;
        rst_n = 1'b0;
        stall = 1'b0;
        branch = 1'b0;
        target = '0;
        bus.imem_req_ready = 1'b1;

        // reset and boot
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_pc", pc_out, 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_BOOT));
        exp_req_q.push_back(RESET_PC);
        exp_req_q.push_back(RESET_PC + 64'd4);
        exp_req_q.push_back(RESET_PC + 64'd8);
        exp_out_q.push_back(RESET_PC);
        exp_out_q.push_back(RESET_PC + 64'd4);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("boot_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("boot_state", 64'(state_dbg), 64'(ST_BOOT));
        wait_accept("first");
        check("first_addr", bus.imem_req_addr, RESET_PC);

        // stall while the next response lands in the skid buffer
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(inst_valid), 64'd1);
            check("stall_pc", pc_out, RESET_PC);
            check("stall_inst", 64'(inst), 64'(mem_fn(RESET_PC)));
        end
        check("stall_state", 64'(state_dbg), 64'(ST_HOLD));
        @(posedge clk);
        #1 stall = 1'b0;
        mem_lat = 3;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("unstall_valid", 64'(inst_valid), 64'd1);
        check("unstall_pc", pc_out, RESET_PC + 64'd4);
        check("unstall_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("unstall_req_addr", bus.imem_req_addr, RESET_PC + 64'd8);

        // redirect while the 0x80000008 request is outstanding
        exp_req_q.push_back(64'h1000);
        exp_out_q.push_back(64'h1000);
        @(posedge clk);
        #1 branch = 1'b1;
        target = 64'h1000;
        @(posedge clk);
        #1 branch = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        check("wredir_valid", 64'(inst_valid), 64'd0);
        check("wredir_state", 64'(state_dbg), 64'(ST_WAIT));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_resp_valid) found = 1'b1;
        end
        check("stale_resp_seen", 64'(found), 64'd1);
        @(negedge clk);
        check("stale_drop_valid", 64'(inst_valid), 64'd0);
        check("wredir_req_addr", bus.imem_req_addr, 64'h1000);
        check("wredir_req_valid", 64'(bus.imem_req_valid), 64'd1);
        @(posedge clk);
        #1 bus.imem_req_ready = 1'b0;
        wait_out("wredir");
        check("wredir_out_pc", pc_out, 64'h1000);

        // retarget without handshake, then redirect coincident with acceptance
        @(posedge clk);
        #1 branch = 1'b1;
        target = 64'h8000_0010;
        @(posedge clk);
        #1 branch = 1'b0;
        @(negedge clk);
        check("noacc_req_addr", bus.imem_req_addr, 64'h8000_0010);
        exp_req_q.push_back(64'h8000_0010);
        exp_req_q.push_back(64'h2000);
        @(posedge clk);
        #1 bus.imem_req_ready = 1'b1;
        branch = 1'b1;
        target = 64'h2000;
        @(posedge clk);
        #1 branch = 1'b0;
        @(negedge clk);
        check("hsredir_state", 64'(state_dbg), 64'(ST_WAIT));
        check("hsredir_req_valid", 64'(bus.imem_req_valid), 64'd0);
        wait_accept("hsredir");
        check("hsredir_addr", bus.imem_req_addr, 64'h2000);
        @(posedge clk);
        #1 bus.imem_req_ready = 1'b0;
        stall = 1'b1;
        wait_out("hsredir");
        check("hsredir_out_pc", pc_out, 64'h2000);

        // redirect and stall together squash the held output
        @(posedge clk);
        #1 branch = 1'b1;
        target = 64'h3000;
        @(posedge clk);
        #1 branch = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("rs_valid", 64'(inst_valid), 64'd0);
        check("rs_req_addr", bus.imem_req_addr, 64'h3000);
        exp_req_q.push_back(64'h3000);
        exp_out_q.push_back(64'h3000);
        @(posedge clk);
        #1 bus.imem_req_ready = 1'b1;
        wait_accept("rs");
        @(posedge clk);
        #1 bus.imem_req_ready = 1'b0;
        wait_out("rs");
        check("rs_out_pc", pc_out, 64'h3000);

        // PC wrap
        @(posedge clk);
        #1 branch = 1'b1;
        target = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_req_q.push_back(64'h0);
        exp_out_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_out_q.push_back(64'h0);
        @(posedge clk);
        #1 branch = 1'b0;
        bus.imem_req_ready = 1'b1;
        wait_accept("wrap_a");
        wait_accept("wrap_b");
        check("wrap_addr", bus.imem_req_addr, 64'h0);
        @(posedge clk);
        #1 bus.imem_req_ready = 1'b0;
        wait_out("wrap");
        check("wrap_out_pc", pc_out, 64'h0);

        // random ready / stall / latency over a sequential stream
        start = acc_cnt;
        for (int i = 0; i < 40; i++) begin
            exp_req_q.push_back(64'h4 + 64'(4 * i));
            exp_out_q.push_back(64'h4 + 64'(4 * i));
        end
        cyc = 0;
        while (exp_out_q.size() > 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            stall = ($urandom_range(0, 3) == 0);
            mem_lat = $urandom_range(1, 3);
            bus.imem_req_ready = (acc_cnt - start < 40) ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
        stall = 1'b0;
        bus.imem_req_ready = 1'b0;
        check("rand_drain", 64'(exp_out_q.size()), 64'd0);

        // reset in WAIT, then a response with no matching request
        @(posedge clk);
        #1 mem_en = 1'b0;
        bus.imem_req_ready = 1'b1;
        exp_req_q.push_back(64'hA4);
        wait_accept("mid");
        @(posedge clk);
        #1 bus.imem_req_ready = 1'b0;
        @(negedge clk);
        check("mid_state", 64'(state_dbg), 64'(ST_WAIT));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("mid_rst_req_addr", bus.imem_req_addr, RESET_PC);
        check("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
        check("mid_rst_inst", 64'(inst), 64'd0);
        check("mid_rst_pc", pc_out, 64'd0);
        check("mid_rst_state", 64'(state_dbg), 64'(ST_BOOT));
        inj_resp = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        inj_resp = 1'b0;
        repeat (2) @(negedge clk);
        check("late_inst_valid", 64'(inst_valid), 64'd0);
        check("late_state", 64'(state_dbg), 64'(ST_REQ));
        check("late_req_addr", bus.imem_req_addr, RESET_PC);
        @(posedge clk);
        #1 mem_en = 1'b1;
        bus.imem_req_ready = 1'b1;
        exp_req_q.push_back(RESET_PC);
        exp_out_q.push_back(RESET_PC);
        wait_accept("post");
        @(posedge clk);
        #1 bus.imem_req_ready = 1'b0;
        wait_out("post");
        check("post_out_pc", pc_out, RESET_PC);
        repeat (3) @(negedge clk);
        check("req_q_empty", 64'(exp_req_q.size()), 64'd0);
        check("out_q_empty", 64'(exp_out_q.size()), 64'd0);

        // report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
